// File: rtl/hazard_ctrl_unit_pkg.sv
// otter_hazard_pkg: shared state encoding and register constants for the hazard controller
package otter_hazard_pkg;
  typedef enum logic [1:0] {RUN, LOAD_STALL, FLUSH, MEM_WAIT} hz_state_t;
  localparam logic [4:0] REG_X0 = 5'd0;
endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (inc && !(&count)) count <= count + W'(1);
endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: load-use stall, branch flush and data-memory wait sequencing for the OTTER pipeline
module hazard_ctrl_unit
  import otter_hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             REG_CLOCK,
  input  logic             REG_RESET,
  input  logic [4:0]       IF_ID_RS1,
  input  logic [4:0]       IF_ID_RS2,
  input  logic             IF_ID_USES_RS1,
  input  logic             IF_ID_USES_RS2,
  input  logic [4:0]       ID_EX_RD,
  input  logic             ID_EX_MEMREAD2,
  input  logic             BRANCH_TAKEN,
  input  logic             DMEM_BUSY,
  output logic             PC_WRITE,
  output logic             IF_ID_WRITE,
  output logic             IF_ID_FLUSH,
  output logic             ID_EX_Controls_Sel,
  output logic             PIPE_HOLD,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  hz_state_t     state;
  logic [CW-1:0] flush_ctr;
  logic          pend_flush, lu_hazard, act, flush, stall;
  assign lu_hazard = ID_EX_MEMREAD2 && ID_EX_RD != REG_X0 &&
                     ((IF_ID_USES_RS1 && IF_ID_RS1 == ID_EX_RD) ||
                      (IF_ID_USES_RS2 && IF_ID_RS2 == ID_EX_RD));
  // act: cycle where branch/hazard logic decides; the MEM_WAIT exit cycle behaves as plain RUN
  assign act   = !REG_RESET && !DMEM_BUSY && state != MEM_WAIT;
  assign flush = act && (BRANCH_TAKEN || state == FLUSH);
  assign stall = act && !flush && lu_hazard;
  assign PIPE_HOLD          = !REG_RESET && DMEM_BUSY;
  assign PC_WRITE           = !REG_RESET && !DMEM_BUSY && !stall;
  assign IF_ID_WRITE        = PC_WRITE;
  assign IF_ID_FLUSH        = flush;
  assign ID_EX_Controls_Sel = !REG_RESET && !flush && !stall;
  always_ff @(posedge REG_CLOCK)
    if (REG_RESET) begin
      state      <= RUN;
      flush_ctr  <= '0;
      pend_flush <= 1'b0;
    end else if (DMEM_BUSY) begin
      state      <= MEM_WAIT;
      pend_flush <= pend_flush || BRANCH_TAKEN;
    end else if (state == MEM_WAIT) begin
      state      <= (pend_flush || flush_ctr != '0) ? FLUSH : RUN;
      flush_ctr  <= pend_flush ? CW'(FLUSH_CYCLES) : flush_ctr;
      pend_flush <= 1'b0;
    end else if (BRANCH_TAKEN) begin
      state     <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      flush_ctr <= CW'(FLUSH_CYCLES - 1);
    end else if (state == FLUSH) begin
      state     <= (flush_ctr <= CW'(1)) ? RUN : FLUSH;
      flush_ctr <= flush_ctr - CW'(1);
    end else
      state <= lu_hazard ? LOAD_STALL : RUN;
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(REG_CLOCK), .rst(REG_RESET), .inc(stall), .count(STALL_CNT)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(REG_CLOCK), .rst(REG_RESET), .inc(act && BRANCH_TAKEN), .count(FLUSH_CNT)
  );
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: directed scoreboard bench for hazard_ctrl_unit with FLUSH_CYCLES=2
module tb_hazard_ctrl_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic        u1 = 1'b0, u2 = 1'b0, ld = 1'b0, br = 1'b0, busy = 1'b0;
  logic        pc_w, ifid_w, ifid_f, sel, hold;
  logic [15:0] stall_cnt, flush_cnt;
  int          n_cmp = 0, n_bad = 0;
  typedef struct {
    string       tag;
    logic [4:0]  o;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;
  exp_t sb[$];
  // expected {PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, Sel, PIPE_HOLD}
  localparam logic [4:0] RSTV = 5'b00000, RUNV = 5'b11010, STLV = 5'b00000,
                         FLSV = 5'b11100, HLDV = 5'b00011;
  hazard_ctrl_unit #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .REG_CLOCK(clk), .REG_RESET(rst),
    .IF_ID_RS1(rs1), .IF_ID_RS2(rs2), .IF_ID_USES_RS1(u1), .IF_ID_USES_RS2(u2),
    .ID_EX_RD(rd), .ID_EX_MEMREAD2(ld), .BRANCH_TAKEN(br), .DMEM_BUSY(busy),
    .PC_WRITE(pc_w), .IF_ID_WRITE(ifid_w), .IF_ID_FLUSH(ifid_f),
    .ID_EX_Controls_Sel(sel), .PIPE_HOLD(hold),
    .STALL_CNT(stall_cnt), .FLUSH_CNT(flush_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input string tag, input logic r, input logic l, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic a1,
                      input logic a2, input logic b, input logic m, input logic [4:0] o,
                      input logic [15:0] sc, input logic [15:0] fc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; ld = l; rd = d; rs1 = s1; rs2 = s2; u1 = a1; u2 = a2; br = b; busy = m;
    e.tag = tag; e.o = o; e.sc = sc; e.fc = fc;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk({e.tag, ".ctl"}, {11'd0, pc_w, ifid_w, ifid_f, sel, hold}, {11'd0, e.o});
    chk({e.tag, ".stall_cnt"}, stall_cnt, e.sc);
    chk({e.tag, ".flush_cnt"}, flush_cnt, e.fc);
  endtask
  initial begin
    //   tag           rst ld rd  rs1 rs2 u1 u2 br bsy exp   sc fc
    step("reset0",     1, 0, 0,  0,  0,  0, 0, 0, 0, RSTV, 0, 0);
    step("reset1",     1, 0, 0,  0,  0,  0, 0, 0, 0, RSTV, 0, 0);
    step("reset2",     1, 0, 0,  0,  0,  0, 0, 0, 0, RSTV, 0, 0);
    step("run0",       0, 0, 0,  0,  0,  0, 0, 0, 0, RUNV, 0, 0);
    step("lu_rs1",     0, 1, 5,  5,  0,  1, 0, 0, 0, STLV, 0, 0);
    step("bubble1",    0, 0, 0,  0,  0,  0, 0, 0, 0, RUNV, 1, 0);
    step("rd_x0",      0, 1, 0,  0,  0,  1, 0, 0, 0, RUNV, 1, 0);
    step("no_use",     0, 1, 5,  5,  0,  0, 0, 0, 0, RUNV, 1, 0);
    step("no_load",    0, 0, 5,  5,  0,  1, 0, 0, 0, RUNV, 1, 0);
    step("lu_rs2",     0, 1, 5,  3,  5,  1, 1, 0, 0, STLV, 1, 0);
    step("bubble2",    0, 0, 0,  0,  0,  0, 0, 0, 0, RUNV, 2, 0);
    step("br",         0, 0, 0,  0,  0,  0, 0, 1, 0, FLSV, 2, 0);
    step("br_fl2",     0, 0, 0,  0,  0,  0, 0, 0, 0, FLSV, 2, 1);
    step("br_done",    0, 0, 0,  0,  0,  0, 0, 0, 0, RUNV, 2, 1);
    step("br_busy1",   0, 0, 0,  0,  0,  0, 0, 1, 1, HLDV, 2, 1);
    step("busy2",      0, 0, 0,  0,  0,  0, 0, 0, 1, HLDV, 2, 1);
    step("busy3",      0, 0, 0,  0,  0,  0, 0, 0, 1, HLDV, 2, 1);
    step("mw_exit",    0, 0, 0,  0,  0,  0, 0, 0, 0, RUNV, 2, 1);
    step("pend_fl1",   0, 0, 0,  0,  0,  0, 0, 0, 0, FLSV, 2, 1);
    step("pend_fl2",   0, 0, 0,  0,  0,  0, 0, 0, 0, FLSV, 2, 1);
    step("pend_done",  0, 0, 0,  0,  0,  0, 0, 0, 0, RUNV, 2, 1);
    step("br_lu",      0, 1, 7,  7,  0,  1, 0, 1, 0, FLSV, 2, 1);
    step("br_lu_fl",   0, 1, 7,  7,  0,  1, 0, 0, 0, FLSV, 2, 2);
    step("br_lu_done", 0, 0, 0,  0,  0,  0, 0, 0, 0, RUNV, 2, 2);
    step("rst_br",     0, 0, 0,  0,  0,  0, 0, 1, 0, FLSV, 2, 2);
    step("restart",    0, 0, 0,  0,  0,  0, 0, 1, 0, FLSV, 2, 3);
    step("restart_fl", 0, 0, 0,  0,  0,  0, 0, 0, 0, FLSV, 2, 4);
    step("restart_dn", 0, 0, 0,  0,  0,  0, 0, 0, 0, RUNV, 2, 4);
    step("br_again",   0, 0, 0,  0,  0,  0, 0, 1, 0, FLSV, 2, 4);
    step("rst_in_fl",  1, 0, 0,  0,  0,  0, 0, 0, 0, RSTV, 2, 5);
    step("after_rst",  0, 0, 0,  0,  0,  0, 0, 0, 0, RUNV, 0, 0);
    step("mw_br",      0, 0, 0,  0,  0,  0, 0, 1, 1, HLDV, 0, 0);
    step("rst_in_mw",  1, 0, 0,  0,  0,  0, 0, 0, 0, RSTV, 0, 0);
    step("mw_cleared", 0, 0, 0,  0,  0,  0, 0, 0, 0, RUNV, 0, 0);
    step("no_pend",    0, 0, 0,  0,  0,  0, 0, 0, 0, RUNV, 0, 0);
    step("busy_lu",    0, 1, 9,  9,  0,  1, 0, 0, 1, HLDV, 0, 0);
    step("busy_lu_ex", 0, 0, 0,  0,  0,  0, 0, 0, 0, RUNV, 0, 0);
    step("busy_lu_dn", 0, 0, 0,  0,  0,  0, 0, 0, 0, RUNV, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
